// File: rtl/parity_tx.sv
// Serial transmitter: 11-bit frame (start, 8 data LSB first, parity, stop) per accepted byte.
// Latency: start bit on tx_out the cycle after accept; frame lasts 11*CLKS_PER_BIT cycles.
// Backpressure: din_ready high only when idle; din_valid is ignored while a frame is in flight.
module parity_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int PAR_ODD      = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Last count of a bit period, and the count one before it (used to
    // pre-register tx_done so it lines up with the final stop-bit cycle).
    localparam logic [7:0] CNT_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] CNT_PRE  = 8'((CLKS_PER_BIT > 1) ? (CLKS_PER_BIT - 2) : 0);
    localparam logic       PAR_INV  = (PAR_ODD != 0);
    localparam logic       ONE_CLK  = (CLKS_PER_BIT == 1);

    state_t     state;
    logic [7:0] bit_cnt;
    logic [2:0] data_idx;
    logic [7:0] shreg;
    logic       par_bit;
    logic       bit_end;

    // Bit boundary: the current bit has been held for its full period.
    assign bit_end = (bit_cnt == CNT_LAST);

    // Frame sequencer; every output is a register so tx_out only moves on bit boundaries.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            data_idx  <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            tx_out    <= 1'b1;
            din_ready <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= 1'b0;

            if (state != IDLE) begin
                bit_cnt <= bit_end ? 8'd0 : bit_cnt + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (din_valid && din_ready) begin
                        // Capture byte and its parity now; din is free to change afterwards.
                        shreg     <= din;
                        par_bit   <= (^din) ^ PAR_INV;
                        state     <= START;
                        tx_out    <= 1'b0;
                        din_ready <= 1'b0;
                        tx_busy   <= 1'b1;
                        bit_cnt   <= 8'd0;
                        data_idx  <= 3'd0;
                    end
                end

                START: begin
                    if (bit_end) begin
                        state    <= DATA;
                        tx_out   <= shreg[0];
                        shreg    <= shreg >> 1;
                        data_idx <= 3'd0;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        if (data_idx == 3'd7) begin
                            state  <= PARITY;
                            tx_out <= par_bit;
                        end else begin
                            data_idx <= data_idx + 3'd1;
                            tx_out   <= shreg[0];
                            shreg    <= shreg >> 1;
                        end
                    end
                end

                PARITY: begin
                    if (bit_end) begin
                        state   <= STOP;
                        tx_out  <= 1'b1;
                        // With a one-cycle bit the stop bit's only cycle is also its last.
                        tx_done <= ONE_CLK;
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        state     <= IDLE;
                        din_ready <= 1'b1;
                        tx_busy   <= 1'b0;
                    end else begin
                        tx_done <= (bit_cnt == CNT_PRE);
                    end
                end

                default: begin
                    state     <= IDLE;
                    bit_cnt   <= '0;
                    tx_out    <= 1'b1;
                    din_ready <= 1'b1;
                    tx_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parity_tx.sv
// Bench for parity_tx: even/odd parity, 4-cycle and 1-cycle bit periods.
// Latency: checks each frame cycle-by-cycle from the accept edge.
// Backpressure: exercises held din_valid, reset with accept and reset mid-frame.
module tb_parity_tx;

    logic       clk;
    logic       rst;
    logic [7:0] din [3];
    logic       vld [3];
    logic       rdy [3];
    logic       txo [3];
    logic       busy [3];
    logic       done [3];

    int err_cnt;
    int chk_cnt;

    // Instance 0: even parity, 4 clocks/bit
    parity_tx #(.CLKS_PER_BIT(4), .PAR_ODD(0)) u_even (
        .clk(clk), .rst(rst), .din(din[0]), .din_valid(vld[0]),
        .din_ready(rdy[0]), .tx_out(txo[0]), .tx_busy(busy[0]), .tx_done(done[0])
    );

    // Instance 1: odd parity, 4 clocks/bit
    parity_tx #(.CLKS_PER_BIT(4), .PAR_ODD(1)) u_odd (
        .clk(clk), .rst(rst), .din(din[1]), .din_valid(vld[1]),
        .din_ready(rdy[1]), .tx_out(txo[1]), .tx_busy(busy[1]), .tx_done(done[1])
    );

    // Instance 2: even parity, 1 clock/bit
    parity_tx #(.CLKS_PER_BIT(1), .PAR_ODD(0)) u_fast (
        .clk(clk), .rst(rst), .din(din[2]), .din_valid(vld[2]),
        .din_ready(rdy[2]), .tx_out(txo[2]), .tx_busy(busy[2]), .tx_done(done[2])
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge with the unit idle. Offers byte d, then checks every
    // frame cycle. With hold=1, din_valid stays high and din is scrambled
    // during the frame; it is left high on return.
    task automatic frame(input int u, input logic [7:0] d, input logic par,
                         input int cpb, input bit hold);
        int  n;
        int  idx;
        logic e;
        n = 11 * cpb;
        din[u] = d;
        vld[u] = 1'b1;
        check("rdy_before_accept", rdy[u], 1);
        @(negedge clk);
        if (!hold) vld[u] = 1'b0;
        for (int k = 1; k <= n; k++) begin
            idx = (k - 1) / cpb;
            if (idx == 0)      e = 1'b0;
            else if (idx <= 8) e = d[idx-1];
            else if (idx == 9) e = par;
            else               e = 1'b1;
            check("tx_bit", txo[u], e);
            check("tx_done", done[u], (k == n));
            check("tx_busy", busy[u], 1);
            check("rdy_in_frame", rdy[u], 0);
            if (hold) din[u] = din[u] ^ 8'hFF;
            @(negedge clk);
        end
        check("rdy_after_done", rdy[u], 1);
        check("busy_after_done", busy[u], 0);
        check("tx_idle_high", txo[u], 1);
        check("done_cleared", done[u], 0);
    endtask

    initial begin
        clk     = 1'b0;
        rst     = 1'b1;
        err_cnt = 0;
        chk_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            din[i] = 8'h00;
            vld[i] = 1'b0;
        end

        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_tx_out", txo[i], 1);
            check("rst_rdy", rdy[i], 1);
            check("rst_busy", busy[i], 0);
            check("rst_done", done[i], 0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Even parity, 4 clocks/bit
        frame(0, 8'hA5, 1'b0, 4, 1'b0);
        frame(0, 8'h07, 1'b1, 4, 1'b0);
        frame(0, 8'h00, 1'b0, 4, 1'b0);
        frame(0, 8'hFF, 1'b0, 4, 1'b0);

        // Odd parity, 4 clocks/bit
        frame(1, 8'hA5, 1'b1, 4, 1'b0);
        frame(1, 8'h07, 1'b0, 4, 1'b0);
        frame(1, 8'h00, 1'b1, 4, 1'b0);
        frame(1, 8'hFF, 1'b1, 4, 1'b0);

        // One clock per bit
        frame(2, 8'h81, 1'b0, 1, 1'b0);
        frame(2, 8'hFF, 1'b0, 1, 1'b0);

        // din_valid held high, din changing mid-frame; back-to-back second frame
        frame(0, 8'h3C, 1'b0, 4, 1'b1);
        frame(0, 8'h01, 1'b1, 4, 1'b0);

        // Reset wins over an accept in the same cycle
        din[0] = 8'h55;
        vld[0] = 1'b1;
        rst    = 1'b1;
        @(negedge clk);
        check("rst_accept_busy", busy[0], 0);
        check("rst_accept_rdy", rdy[0], 1);
        check("rst_accept_tx", txo[0], 1);
        rst    = 1'b0;
        vld[0] = 1'b0;
        @(negedge clk);
        check("rst_accept_idle", busy[0], 0);

        // Reset during data bit 3 (cycles 17..20 after accept)
        din[0] = 8'hA5;
        vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        repeat (17) @(negedge clk);
        check("mid_bit3", txo[0], 0);
        check("mid_busy", busy[0], 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_tx", txo[0], 1);
        check("abort_busy", busy[0], 0);
        check("abort_rdy", rdy[0], 1);
        check("abort_done", done[0], 0);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            check("abort_no_done", done[0], 0);
            check("abort_line_high", txo[0], 1);
        end
        frame(0, 8'h5A, 1'b0, 4, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
